// File: rtl/countdown_sequencer.sv
// Programmable down-count timer sequencing a cascaded 4-bit ripple decrementer.
// Optional prescaler enabled by defining COUNTDOWN_SEQUENCER_PRESCALE_EN.
module countdown_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int SLICES = WIDTH / 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] EXPIRE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_q;
  logic             auto_q;
  logic [WIDTH-1:0] dec;
  logic [SLICES-1:0] borrow;
  logic             step;

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN) || (state == EXPIRE);

  // Ripple decrementer: each slice borrows from the next only when it is zero.
  assign borrow[0] = 1'b1;
  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [3:0] nib;
    assign nib            = count[4*s +: 4];
    assign dec[4*s +: 4]  = nib - {3'b000, borrow[s]};
    if (s + 1 < SLICES) begin : g_chain
      assign borrow[s+1] = borrow[s] & (nib == 4'd0);
    end
  end

`ifdef COUNTDOWN_SEQUENCER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  assign step = (state == RUN) && !pause && (ps == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps <= '0;
    end else if (abort || state != RUN) begin
      // Covers load acceptance (IDLE) and reload (EXPIRE) as well as abort.
      ps <= '0;
    end else if (!pause) begin
      ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
    end
  end
`else
  // PRESCALE is ignored here; the comparison is constant-true for legal values.
  assign step = (state == RUN) && !pause && (PRESCALE >= 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      count  <= '0;
      auto_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            count    <= load_value;
            reload_q <= load_value;
            auto_q   <= auto_reload;
            if (load_value == '0) begin
              state <= EXPIRE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          done <= 1'b0;
          if (step) begin
            // A count of 0 here is defensive: expire rather than wrap.
            if (count <= WIDTH'(1)) begin
              count <= '0;
              state <= EXPIRE;
              done  <= 1'b1;
            end else begin
              count <= dec;
            end
          end
        end
        EXPIRE: begin
          if (auto_q) begin
            count <= reload_q;
            if (reload_q != '0) begin
              state <= RUN;
              done  <= 1'b0;
            end else begin
              state <= EXPIRE;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a behavioural timer model and literal pins.
`timescale 1ns/1ps
module tb_countdown_sequencer;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef COUNTDOWN_SEQUENCER_PRESCALE_EN
  localparam int STEP_PERIOD = PRESCALE;
`else
  localparam int STEP_PERIOD = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  countdown_sequencer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .auto_reload(auto_reload), .pause(pause),
    .abort(abort), .count(count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timer model: phase 0 idle, 1 counting, 2 expired (done cycle).
  int               m_phase;
  int               m_ps;
  logic [WIDTH-1:0] m_count;
  logic [WIDTH-1:0] m_reload;
  bit               m_auto;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ps = 0; m_count = '0; m_reload = '0; m_auto = 0;
    end else if (abort) begin
      m_phase = 0; m_ps = 0; m_count = '0; m_auto = 0;
    end else if (m_phase == 0) begin
      if (load_valid) begin
        m_count  = load_value;
        m_reload = load_value;
        m_auto   = auto_reload;
        m_ps     = 0;
        m_phase  = (load_value == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (!pause) begin
        if (m_ps == STEP_PERIOD - 1) begin
          m_ps = 0;
          if (m_count <= 1) begin
            m_count = '0;
            m_phase = 2;
          end else begin
            m_count = m_count - 1'b1;
          end
        end else begin
          m_ps = m_ps + 1;
        end
      end
    end else begin
      m_ps = 0;
      if (m_auto) begin
        m_count = m_reload;
        m_phase = (m_reload != 0) ? 1 : 2;
      end else begin
        m_phase = 0;
        m_count = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_done", 32'(done), 32'(m_phase == 2));
    chk("model_busy", 32'(busy), 32'(m_phase != 0));
    chk("model_load_ready", 32'(load_ready), 32'(m_phase == 0));
  end

  task automatic step_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a load for one edge; returns at the negedge after acceptance.
  task automatic drive_load(input int v, input bit a);
    load_valid  = 1'b1;
    load_value  = WIDTH'(v);
    auto_reload = a;
    @(negedge clk);
    load_valid  = 1'b0;
    auto_reload = 1'b0;
  endtask

  int exp_a_count [6]  = '{4, 3, 2, 1, 0, 0};
  int exp_a_done  [6]  = '{0, 0, 0, 0, 1, 0};
  int exp_c_count [12] = '{6, 5, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    int done_idx;
    bit done_seen;
    rst_n = 1'b0; load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
    pause = 1'b0; abort = 1'b0;
    step_n(2);
    chk("reset_count", 32'(count), 0);
    chk("reset_load_ready", 32'(load_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    step_n(1);

`ifndef COUNTDOWN_SEQUENCER_PRESCALE_EN
    // Load 4, single shot
    drive_load(4, 0);
    for (int i = 0; i < 6; i++) begin
      chk("a_count", 32'(count), 32'(exp_a_count[i]));
      chk("a_done", 32'(done), 32'(exp_a_done[i]));
      if (i < 5) @(negedge clk);
    end
    chk("a_load_ready", 32'(load_ready), 1);

    // Load 3, auto reload, with ignored load attempts while running
    drive_load(3, 1);
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b0;
      chk("b_count", 32'(count), 32'(3 - (i % 4)));
      chk("b_done", 32'(done), 32'((i % 4) == 3));
      if (i == 1 || i == 5) begin
        load_valid = 1'b1;
        load_value = WIDTH'(9);
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("b_abort_count", 32'(count), 0);
    chk("b_abort_ready", 32'(load_ready), 1);

    // Load 6 with a 3-cycle pause while count is 4
    drive_load(6, 0);
    done_idx = -1;
    for (int i = 0; i < 12; i++) begin
      chk("c_count", 32'(count), 32'(exp_c_count[i]));
      if (done && done_idx < 0) done_idx = i;
      if (i == 2) pause = 1'b1;
      if (i == 5) pause = 1'b0;
      @(negedge clk);
    end
    chk("c_done_cycle", 32'(done_idx), 9);

    // Zero-length timer
    drive_load(0, 0);
    chk("d_done", 32'(done), 1);
    chk("d_busy", 32'(busy), 1);
    chk("d_count", 32'(count), 0);
    @(negedge clk);
    chk("d_done_after", 32'(done), 0);
    chk("d_busy_after", 32'(busy), 0);
    chk("d_ready_after", 32'(load_ready), 1);

    // Abort at count 2 in auto-reload mode
    drive_load(5, 1);
    step_n(3);
    chk("e_count_before_abort", 32'(count), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("e_count", 32'(count), 0);
    chk("e_busy", 32'(busy), 0);
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("e_no_done", 32'(done_seen), 0);

    // Load together with abort in IDLE is dropped
    load_valid = 1'b1; load_value = WIDTH'(7); abort = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; abort = 1'b0;
    chk("e_drop_count", 32'(count), 0);
    chk("e_drop_ready", 32'(load_ready), 1);

    // Asynchronous reset mid-run at count 5
    drive_load(8, 0);
    step_n(3);
    chk("f_count_before_reset", 32'(count), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("f_count", 32'(count), 0);
    chk("f_done", 32'(done), 0);
    chk("f_busy", 32'(busy), 0);
    chk("f_load_ready", 32'(load_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Boundaries: full-scale load, load of 1 with reload
    drive_load(15, 0);
    step_n(14);
    chk("g_last_step_count", 32'(count), 1);
    @(negedge clk);
    chk("g_full_done", 32'(done), 1);
    step_n(1);
    drive_load(1, 1);
    for (int i = 0; i < 6; i++) begin
      chk("g_reload1_done", 32'(done), 32'((i % 2) == 1));
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`else
    // Prescaled load of 3: count moves every PRESCALE cycles
    drive_load(3, 0);
    done_idx = -1;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) chk("p_count", 32'(count), 32'(3 - i / 4));
      if (done && done_idx < 0) done_idx = i;
      @(negedge clk);
    end
    chk("p_done_cycle", 32'(done_idx), 12);

    // Prescaled run with pause and auto reload, checked by the model
    drive_load(2, 1);
    step_n(3);
    pause = 1'b1;
    step_n(3);
    pause = 1'b0;
    step_n(20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("p_abort_count", 32'(count), 0);
`endif

    step_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
